// File: rtl/shadow_dump_ctrl.sv
// shadow_dump_ctrl: captures words into a circular shadow buffer, then on
// request dumps the buffer oldest-first over CH serial channels, where each
// channel carries one S-bit slice of every word, LSB first.
module shadow_dump_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CH     = 2,
  parameter int unsigned WRAP   = 1
) (
  input  logic                   sh_clk,
  input  logic                   sh_rst_l,
  input  logic                   c_en,
  input  logic                   cap_vld,
  input  logic [DATA_W-1:0]      cap_data,
  input  logic [CH-1:0]          dump_en,
  output logic [CH-1:0]          ch_out,
  output logic [CH-1:0]          ch_out_vld,
  output logic [CH-1:0]          ch_out_done,
  output logic [$clog2(DEPTH):0] buf_count,
  output logic                   buf_overflow,
  output logic                   dump_busy
);

  localparam int unsigned S  = DATA_W / CH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    CAPTURE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     words_q, words_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CH-1:0]     mask_q, mask_d;
  logic [CH-1:0]     out_q, out_d;
  logic [CH-1:0]     vld_q, vld_d;
  logic [CH-1:0]     done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [DATA_W-1:0] cur_word;
  logic [S-1:0]      bit_sel;
  logic [CH-1:0]     cur_bits;
  logic              cap_fire;

  assign cap_fire = c_en & cap_vld;
  assign cur_word = mem[rd_ptr_q];
  assign bit_sel  = S'(1) << bit_q;

  // Pick the current bit of each channel's slice of the word being dumped.
  for (genvar gk = 0; gk < CH; gk++) begin : g_slice
    assign cur_bits[gk] = |(cur_word[gk*S +: S] & bit_sel);
  end

  // Next-state, pointer and registered-output computation for the FSM.
  // Outputs are computed from the current state, so they appear one edge
  // after the state they describe (vld trails SHIFT, done trails DONE).
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    base_d   = base_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    words_d  = words_q;
    bit_d    = bit_q;
    mask_d   = mask_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    out_d    = '0;
    vld_d    = '0;
    done_d   = '0;
    mem_we   = 1'b0;

    case (state_q)
      CAPTURE: begin
        if (cap_fire) begin
          if (cnt_q < CW'(DEPTH)) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
            if (WRAP != 0) begin
              // Full: overwrite the oldest entry and move the read base past it.
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              base_d   = base_q + 1'b1;
            end
          end
        end
        if (dump_en != '0) begin
          state_d = LOAD;
          mask_d  = dump_en;
          busy_d  = 1'b1;
        end
      end

      LOAD: begin
        words_d  = cnt_q;
        rd_ptr_d = base_q;
        bit_d    = '0;
        state_d  = (cnt_q != '0) ? SHIFT : DONE;
      end

      SHIFT: begin
        out_d = mask_q & cur_bits;
        vld_d = mask_q;
        if (bit_q == BW'(S - 1)) begin
          bit_d    = '0;
          rd_ptr_d = rd_ptr_q + 1'b1;
          words_d  = words_q - 1'b1;
          if (words_q == CW'(1)) begin
            state_d = DONE;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end

      DONE: begin
        if (dump_en == '0) begin
          state_d  = CAPTURE;
          cnt_d    = '0;
          wr_ptr_d = '0;
          base_d   = '0;
          rd_ptr_d = '0;
          ovf_d    = 1'b0;
          mask_d   = '0;
          busy_d   = 1'b0;
        end else begin
          done_d = mask_q;
        end
      end

      default: state_d = CAPTURE;
    endcase
  end

  // Buffer storage; contents are not reset.
  always_ff @(posedge sh_clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= cap_data;
    end
  end

  // FSM state, pointers and registered outputs.
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      state_q  <= CAPTURE;
      wr_ptr_q <= '0;
      base_q   <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      words_q  <= '0;
      bit_q    <= '0;
      mask_q   <= '0;
      out_q    <= '0;
      vld_q    <= '0;
      done_q   <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      base_q   <= base_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      bit_q    <= bit_d;
      mask_q   <= mask_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign ch_out       = out_q;
  assign ch_out_vld   = vld_q;
  assign ch_out_done  = done_q;
  assign buf_count    = cnt_q;
  assign buf_overflow = ovf_q;
  assign dump_busy    = busy_q;

endmodule

// File: tb/tb_shadow_dump_ctrl.sv
// Testbench for shadow_dump_ctrl: two instances (index 1 overwrites when full,
// index 0 drops when full) share one stimulus stream and are checked against
// a queue-based model of the buffer and the serial dump order.
module tb_shadow_dump_ctrl;

  logic       sh_clk = 1'b0;
  logic       sh_rst_l;
  logic       c_en;
  logic       cap_vld;
  logic [7:0] cap_data;
  logic [1:0] dump_en;

  logic [1:0] ch_out_w [2];
  logic [1:0] vld_w    [2];
  logic [1:0] done_w   [2];
  logic [2:0] cnt_w    [2];
  logic       ovf_w    [2];
  logic       busy_w   [2];

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  bit          ovf_m [2];
  logic [31:0] rec [2][2];

  always #5 sh_clk = ~sh_clk;

  shadow_dump_ctrl #(.DATA_W(8), .DEPTH(4), .CH(2), .WRAP(1)) u_wrap (
    .sh_clk(sh_clk), .sh_rst_l(sh_rst_l), .c_en(c_en), .cap_vld(cap_vld),
    .cap_data(cap_data), .dump_en(dump_en), .ch_out(ch_out_w[1]),
    .ch_out_vld(vld_w[1]), .ch_out_done(done_w[1]), .buf_count(cnt_w[1]),
    .buf_overflow(ovf_w[1]), .dump_busy(busy_w[1])
  );

  shadow_dump_ctrl #(.DATA_W(8), .DEPTH(4), .CH(2), .WRAP(0)) u_drop (
    .sh_clk(sh_clk), .sh_rst_l(sh_rst_l), .c_en(c_en), .cap_vld(cap_vld),
    .cap_data(cap_data), .dump_en(dump_en), .ch_out(ch_out_w[0]),
    .ch_out_vld(vld_w[0]), .ch_out_done(done_w[0]), .buf_count(cnt_w[0]),
    .buf_overflow(ovf_w[0]), .dump_busy(busy_w[0])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sh_clk);
    #1;
  endtask

  function automatic int msize(input int i);
    return (i == 1) ? q1.size() : q0.size();
  endfunction

  function automatic logic [7:0] mword(input int i, input int j);
    return (i == 1) ? q1[j] : q0[j];
  endfunction

  // Bit t of the dump stream on channel k: word t/4, slice bit t%4.
  function automatic logic exp_bit(input int i, input int k, input int t, input logic [1:0] m);
    logic [7:0] w;
    logic [7:0] sh;
    logic [1:0] ms;
    w  = mword(i, t / 4);
    sh = w >> (k * 4 + t % 4);
    ms = m >> k;
    return ms[0] & sh[0];
  endfunction

  task automatic model_capture(input logic [7:0] w);
    if (q1.size() < 4) q1.push_back(w);
    else begin
      void'(q1.pop_front());
      q1.push_back(w);
      ovf_m[1] = 1'b1;
    end
    if (q0.size() < 4) q0.push_back(w);
    else ovf_m[0] = 1'b1;
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    ovf_m[0] = 1'b0;
    ovf_m[1] = 1'b0;
  endtask

  task automatic capture(input logic [7:0] w);
    c_en = 1'b1; cap_vld = 1'b1; cap_data = w;
    tick();
    model_capture(w);
    c_en = 1'b0; cap_vld = 1'b0;
  endtask

  task automatic rand_captures(input int n);
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        c_en = 1'($urandom_range(0, 1)); cap_vld = ~c_en; cap_data = 8'($urandom);
        tick();
      end
      capture(8'($urandom));
    end
  endtask

  task automatic check_static(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i), 32'(cnt_w[i]), 32'(msize(i)));
      chk($sformatf("%s_ovf%0d", tag, i), 32'(ovf_w[i]), 32'(ovf_m[i]));
    end
  endtask

  task automatic do_dump(input string tag, input logic [1:0] m, input bit cap_same, input logic [7:0] w);
    int n;
    for (int i = 0; i < 2; i++) begin rec[i][0] = '0; rec[i][1] = '0; end
    dump_en = m;
    if (cap_same) begin c_en = 1'b1; cap_vld = 1'b1; cap_data = w; end
    tick();
    if (cap_same) model_capture(w);
    c_en = 1'b0; cap_vld = 1'b0;
    n = msize(0) * 4;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_w[i]), 32'd1);
      chk($sformatf("%s_vld_e0_%0d", tag, i), 32'(vld_w[i]), 32'd0);
    end
    check_static({tag, "_e0"});
    dump_en = 2'($urandom); c_en = 1'($urandom); cap_vld = 1'($urandom); cap_data = 8'($urandom);
    tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_vld_load%0d", tag, i), 32'(vld_w[i]), 32'd0);
    for (int t = 0; t < n; t++) begin
      dump_en = 2'($urandom); c_en = 1'($urandom); cap_vld = 1'($urandom); cap_data = 8'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("%s_vld%0d_t%0d", tag, i, t), 32'(vld_w[i]), 32'(m));
        chk($sformatf("%s_out%0d_t%0d", tag, i, t), 32'(ch_out_w[i]),
            32'({exp_bit(i, 1, t, m), exp_bit(i, 0, t, m)}));
        rec[i][0][t] = ch_out_w[i][0];
        rec[i][1][t] = ch_out_w[i][1];
      end
    end
    c_en = 1'b0; cap_vld = 1'b0; dump_en = m;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_vld_end%0d", tag, i), 32'(vld_w[i]), 32'd0);
      chk($sformatf("%s_out_end%0d", tag, i), 32'(ch_out_w[i]), 32'd0);
      chk($sformatf("%s_done%0d", tag, i), 32'(done_w[i]), 32'(m));
      chk($sformatf("%s_busy_done%0d", tag, i), 32'(busy_w[i]), 32'd1);
    end
    check_static({tag, "_done"});
    tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_done_hold%0d", tag, i), 32'(done_w[i]), 32'(m));
    dump_en = 2'b00;
    tick();
    model_clear();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_done_clr%0d", tag, i), 32'(done_w[i]), 32'd0);
      chk($sformatf("%s_busy_clr%0d", tag, i), 32'(busy_w[i]), 32'd0);
    end
    check_static({tag, "_clr"});
  endtask

  initial begin
    sh_rst_l = 1'b1; c_en = 1'b0; cap_vld = 1'b0; cap_data = '0; dump_en = '0;
    model_clear();

    #2 sh_rst_l = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out%0d", i), 32'(ch_out_w[i]), 32'd0);
      chk($sformatf("rst_vld%0d", i), 32'(vld_w[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
      chk($sformatf("rst_cnt%0d", i), 32'(cnt_w[i]), 32'd0);
      chk($sformatf("rst_ovf%0d", i), 32'(ovf_w[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
    end
    tick();
    tick();
    sh_rst_l = 1'b1;
    tick();

    // Two-word dump on both channels.
    capture(8'hA5);
    capture(8'h3C);
    check_static("a5_3c");
    do_dump("a5_3c", 2'b11, 1'b0, 8'h00);
    chk("a5_3c_ch0_seq", rec[1][0], 32'h0000_00C5);
    chk("a5_3c_ch1_seq", rec[1][1], 32'h0000_003A);

    // Overfill: overwrite vs drop.
    for (int w = 1; w <= 6; w++) capture(8'(w));
    chk("fill_cnt_wrap", 32'(cnt_w[1]), 32'd4);
    chk("fill_ovf_wrap", 32'(ovf_w[1]), 32'd1);
    chk("fill_cnt_drop", 32'(cnt_w[0]), 32'd4);
    chk("fill_ovf_drop", 32'(ovf_w[0]), 32'd1);
    do_dump("fill", 2'b11, 1'b0, 8'h00);
    chk("fill_wrap_seq", rec[1][0], 32'h0000_6543);
    chk("fill_drop_seq", rec[0][0], 32'h0000_4321);

    // Empty buffer dump.
    do_dump("empty", 2'b01, 1'b0, 8'h00);

    // Capture on the same edge that samples dump_en, partial and full buffer.
    capture(8'h5A);
    do_dump("same_edge", 2'b10, 1'b1, 8'hC3);
    for (int w = 0; w < 4; w++) capture(8'h90 + 8'(w));
    do_dump("same_full", 2'b11, 1'b1, 8'hE7);

    // Randomised rounds.
    for (int r = 0; r < 10; r++) begin
      rand_captures($urandom_range(0, 6));
      check_static($sformatf("rnd%0d", r));
      do_dump($sformatf("rnd%0d", r), 2'($urandom_range(1, 3)),
              1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset in the middle of a dump.
    capture(8'h11);
    capture(8'h22);
    capture(8'h33);
    dump_en = 2'b11;
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("mid_vld_pre%0d", i), 32'(vld_w[i]), 32'd3);
    #2 sh_rst_l = 1'b0;
    dump_en = 2'b00;
    #1;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mid_vld%0d", i), 32'(vld_w[i]), 32'd0);
      chk($sformatf("mid_out%0d", i), 32'(ch_out_w[i]), 32'd0);
      chk($sformatf("mid_busy%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("mid_done%0d", i), 32'(done_w[i]), 32'd0);
    end
    check_static("mid_rst");
    #2 sh_rst_l = 1'b1;
    tick();

    // Normal operation after reset.
    rand_captures(5);
    check_static("post");
    do_dump("post", 2'b11, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shadow_dump_ctrl.md
SHADOW_DUMP_CTRL -- requirements
Module: shadow_dump_ctrl

Interface
REQ-001 Parameter DATA_W, 64, width of one captured word; DATA_W SHALL be a multiple of CH.
REQ-002 Parameter DEPTH, 8, capture buffer entries; DEPTH SHALL be a power of two, >= 2.
REQ-003 Parameter CH, 2, number of serial dump channels; S = DATA_W/CH bits per channel slice.
REQ-004 Parameter WRAP, 1, 1 = overwrite oldest when full, 0 = drop new words when full.
REQ-005 sh_clk  in  1  sole clock; every flop SHALL be clocked by the rising edge of sh_clk.
REQ-006 sh_rst_l  in  1  reset; asynchronous, active-low.
REQ-007 c_en  in  1  capture enable.
REQ-008 cap_vld  in  1  cap_data qualifier.
REQ-009 cap_data  in  DATA_W  word to capture.
REQ-010 dump_en  in  CH  per-channel dump request.
REQ-011 ch_out  out  CH  serial dump bit per channel.
REQ-012 ch_out_vld  out  CH  ch_out qualifier per channel.
REQ-013 ch_out_done  out  CH  per-channel dump-complete flag.
REQ-014 buf_count  out  clog2(DEPTH)+1  words held in the buffer.
REQ-015 buf_overflow  out  1  sticky: a capture overwrote or was dropped.
REQ-016 dump_busy  out  1  high in LOAD, SHIFT and DONE.

Function
REQ-017 FSM states: CAPTURE, LOAD, SHIFT, DONE; reset state CAPTURE.
REQ-018 In CAPTURE, a word SHALL be written at each edge with c_en=1 and cap_vld=1; buf_count increments, saturating at DEPTH.
REQ-019 Write while full with WRAP=1: the oldest entry is overwritten, the read base advances, buf_count stays DEPTH, buf_overflow sets.
REQ-020 Write while full with WRAP=0: the word is discarded, buffer unchanged, buf_overflow sets.
REQ-021 CAPTURE -> LOAD at the edge sampling dump_en != 0; a capture at that same edge SHALL be stored and included in the dump.
REQ-022 LOAD latches mask = dump_en, word count = buf_count, read pointer = oldest entry; LOAD -> SHIFT if count != 0, else LOAD -> DONE.
REQ-023 In SHIFT, channel k SHALL emit bits [k*S+S-1 : k*S] of the current word, LSB first, one bit per cycle, oldest word first.
REQ-024 ch_out and ch_out_vld are registered; the first ch_out_vld is visible the cycle after the LOAD -> SHIFT edge.
REQ-025 ch_out_vld[k] = mask[k] for exactly count*S consecutive cycles; ch_out[k] SHALL be 0 whenever ch_out_vld[k]=0.
REQ-026 SHIFT -> DONE after the last bit of the last word; no gap between words.
REQ-027 Captures in LOAD, SHIFT and DONE SHALL be ignored and SHALL NOT set buf_overflow.
REQ-028 Changes of dump_en in LOAD or SHIFT SHALL be ignored; the latched mask governs.
REQ-029 In DONE, ch_out_done = mask, held until dump_en == 0; DONE -> CAPTURE at that edge, with buf_count, pointers and buf_overflow cleared.
REQ-030 Pointers SHALL wrap modulo DEPTH; buf_count SHALL never exceed DEPTH.

Reset
REQ-031 sh_rst_l=0 SHALL immediately force state CAPTURE and clear all outputs, buf_count, buf_overflow, pointers and mask, including mid-dump; buffer contents need not be cleared.

Verification (bench: DATA_W=8, DEPTH=4, CH=2, S=4)
REQ-032 Assert sh_rst_l=0 -> all outputs 0, buf_count=0, dump_busy=0.
REQ-033 Capture 0xA5, 0x3C; dump_en=2'b11 -> ch_out[0] = 1,0,1,0,0,0,1,1; ch_out[1] = 0,1,0,1,1,1,0,0; vld high 8 cycles; then done=2'b11 until dump_en=0; buf_count=0.
REQ-034 WRAP=1, capture 0x01..0x06 -> buf_count=4, buf_overflow=1; dump emits 0x03, 0x04, 0x05, 0x06.
REQ-035 WRAP=0, capture 0x01..0x06 -> buf_count=4, buf_overflow=1; dump emits 0x01..0x04.
REQ-036 Empty buffer, dump_en=2'b01 -> no ch_out_vld; done=2'b01 two edges after the sampling edge; done[1]=0.
REQ-037 sh_rst_l=0 during the 3rd SHIFT cycle -> ch_out_vld=0 and dump_busy=0 immediately, buf_count=0.
